// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
//   DW / CNT_W   : operand width and iteration counter width (2**CNT_W > DW)
//   DIV_HILO_WD  : width of the {hi_we, hi, lo_we, lo} result bus
//   div_state_e  : divider FSM states
//   div_hilo_t   : packed layout of the hilo result bus
package ex_div_unit_pkg;

  localparam int unsigned DW          = 32;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned DIV_HILO_WD = 66;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Stall request levels
  localparam logic DivFree = 1'b0;
  localparam logic DivBusy = 1'b1;

  typedef struct packed {
    logic          hi_we;
    logic [DW-1:0] hi;
    logic          lo_we;
    logic [DW-1:0] lo;
  } div_hilo_t;

  // Magnitude in DW+1 bits so that the most negative value cannot overflow
  function automatic logic [DW:0] div_mag(input logic [DW-1:0] v, input logic sgn);
    logic [DW:0] ext;
    ext = {sgn & v[DW-1], v};
    if (sgn && v[DW-1]) begin
      return (DW+1)'(0) - ext;
    end
    return ext;
  endfunction

endpackage

// File: rtl/ex_div_unit_step.sv
// One restoring division iteration (combinational).
//   rem, quot   : current partial remainder and dividend/quotient shift register
//   divisor     : divisor magnitude
//   rem_next    : partial remainder after this step
//   quot_next   : quotient register shifted left with the new quotient bit
module ex_div_unit_step
  import ex_div_unit_pkg::*;
(
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] quot,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic [DW-1:0] quot_next
);

  logic [DW:0] sh_rem;
  logic        ge;

  // Shifted remainder needs DW+1 bits: rem < divisor can be close to 2**DW
  assign sh_rem    = {rem, quot[DW-1]};
  assign ge        = (sh_rem >= {1'b0, divisor});
  assign rem_next  = ge ? DW'(sh_rem - {1'b0, divisor}) : sh_rem[DW-1:0];
  assign quot_next = {quot[DW-2:0], ge};

endmodule

// File: rtl/ex_div_unit.sv
// Iterative 32-bit signed/unsigned divider for DIV/DIVU in the EX stage.
//   clk, rst          : clock and asynchronous active-low reset
//   div_start         : DIV/DIVU with valid operands in EX (sampled in IDLE)
//   div_signed        : 1 = DIV, 0 = DIVU
//   div_src1/div_src2 : dividend / divisor
//   annul             : flush of the EX instruction, aborts any operation
//   ex_adv            : EX/MEM register loads this cycle
//   stallreq_for_div  : combinational stall request to CTRL
//   div_hilo_bus      : registered {hi_we, hi=remainder, lo_we, lo=quotient}
module ex_div_unit
  import ex_div_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   div_start,
  input  logic                   div_signed,
  input  logic [DW-1:0]          div_src1,
  input  logic [DW-1:0]          div_src2,
  input  logic                   annul,
  input  logic                   ex_adv,
  output logic                   stallreq_for_div,
  output logic [DIV_HILO_WD-1:0] div_hilo_bus
);

  div_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]  rem_q, rem_d;
  logic [DW-1:0]  quot_q, quot_d;
  logic [DW-1:0]  dvsr_q, dvsr_d;
  logic [DW-1:0]  src1_q, src1_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           dz_q, dz_d;
  div_hilo_t      bus_q, bus_d;
  logic           stall_c;

  logic [DW-1:0]  step_rem, step_quot;
  logic [DW-1:0]  fix_rem, fix_quot;

  ex_div_unit_step u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (dvsr_q),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  // Sign fixup applied to the final iteration's output
  assign fix_quot = negq_q ? (DW'(0) - step_quot) : step_quot;
  assign fix_rem  = negr_q ? (DW'(0) - step_rem)  : step_rem;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      src1_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      bus_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      src1_q <= src1_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
      bus_q  <= bus_d;
    end
  end

  // Next-state, datapath update and stall request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    src1_d  = src1_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    bus_d   = bus_q;
    stall_c = DivFree;

    if (annul) begin
      // Flush wins over everything, including a simultaneous start
      state_d = DIV_IDLE;
      bus_d   = '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (div_start) begin
            stall_c = DivBusy;
            state_d = DIV_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quot_d  = DW'(div_mag(div_src1, div_signed));
            dvsr_d  = DW'(div_mag(div_src2, div_signed));
            src1_d  = div_src1;
            negq_d  = div_signed & (div_src1[DW-1] ^ div_src2[DW-1]);
            negr_d  = div_signed & div_src1[DW-1];
            dz_d    = (div_src2 == '0);
          end
        end
        DIV_CALC: begin
          stall_c = DivBusy;
          rem_d   = step_rem;
          quot_d  = step_quot;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DW - 1)) begin
            state_d = DIV_DONE;
            if (dz_q) begin
              bus_d = '{hi_we: 1'b1, hi: src1_q, lo_we: 1'b1, lo: '1};
            end else begin
              bus_d = '{hi_we: 1'b1, hi: fix_rem, lo_we: 1'b1, lo: fix_quot};
            end
          end
        end
        DIV_DONE: begin
          if (ex_adv) begin
            state_d = DIV_IDLE;
            bus_d   = '0;
          end
        end
        default: begin
          state_d = DIV_IDLE;
          bus_d   = '0;
        end
      endcase
    end
  end

  // Reset forces the stall low immediately, even with div_start held high
  assign stallreq_for_div = rst ? stall_c : DivFree;
  assign div_hilo_bus     = bus_q;

endmodule
